rgb_frame_writer: RTL and testbench

RGB_FRAME_WRITER -- requirements
Module: rgb_frame_writer

---
 rtl/rgb_pkg.sv | 32 +++
 rtl/rgb_frame_writer_if.sv | 25 ++
 rtl/rgb_pixel_packer.sv | 35 +++
 rtl/rgb_frame_writer.sv | 197 +++++++++++++++++++
 tb/tb_rgb_frame_writer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared pixel-format types, packing helpers and frame-size constants.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rgb_pkg;

    localparam int DEFAULT_IMAGE_W = 80;
    localparam int DEFAULT_IMAGE_H = 48;
    localparam int IMAGE_SIZE      = DEFAULT_IMAGE_W * DEFAULT_IMAGE_H;

    // Output pixel format, selected per frame.
    typedef enum logic {
        PIX_RGB565 = 1'b0,
        PIX_RGB332 = 1'b1
    } pixMode_t;

    // Frame writer control states.
    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } frameState_t;

    // Truncate 8:8:8 to 5:6:5, one pixel per RAM word.
    function automatic logic [15:0] packRgb565(input logic [23:0] pix);
        return {pix[23:19], pix[15:10], pix[7:3]};
    endfunction

    // Truncate 8:8:8 to 3:3:2, two pixels per RAM word.
    function automatic logic [7:0] packRgb332(input logic [23:0] pix);
        return {pix[23:21], pix[15:13], pix[7:6]};
    endfunction

endpackage

// File: rtl/rgb_frame_writer_if.sv
// RAM write bus carried from the frame writer to the frame-buffer memory.
// Latency: n/a (wires only).
// Backpressure: none; the memory must take a write on every strobed cycle.
interface rgb_frame_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);

    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramData;
    logic              writeEnable;

    modport master (
        output ramAddr,
        output ramData,
        output writeEnable
    );

    modport slave (
        input ramAddr,
        input ramData,
        input writeEnable
    );

endinterface

// File: rtl/rgb_pixel_packer.sv
// Pairs consecutive RGB332 pixels into one 16-bit word, even pixel in the high byte.
// Latency: combinational word out on the odd pixel; the even byte is held one or more cycles.
// Backpressure: none; a held even byte is dropped when clear is raised.
module rgb_pixel_packer
    import rgb_pkg::*;
(
    input  logic        rgbClk,
    input  logic        nrst,
    input  logic        clear,
    input  logic        pixValid,
    input  logic [23:0] rgb,
    output logic        pairValid,
    output logic [15:0] pairWord
);

    logic       oddPhase;
    logic [7:0] highByte;

    // Track pair phase and hold the even pixel until its partner arrives.
    always_ff @(posedge rgbClk) begin
        if (!nrst || clear) begin
            oddPhase <= 1'b0;
            highByte <= 8'd0;
        end else if (pixValid) begin
            oddPhase <= ~oddPhase;
            if (!oddPhase) begin
                highByte <= packRgb332(rgb);
            end
        end
    end

    assign pairValid = pixValid & oddPhase;
    assign pairWord  = {highByte, packRgb332(rgb)};

endmodule

// File: rtl/rgb_frame_writer.sv
// Writes an RGB video stream into NB_BUFFERS rotating frame buffers as RGB565 or RGB332.
// Latency: write is registered one cycle after its last contributing pixel; frameDone one cycle after the marker.
// Backpressure: none; at most one RAM write per cycle, the memory must always accept it.
module rgb_frame_writer
    import rgb_pkg::*;
#(
    parameter int IMAGE_W        = DEFAULT_IMAGE_W,
    parameter int IMAGE_H        = DEFAULT_IMAGE_H,
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int RAM_DATA_WIDTH = 16,
    parameter int NB_BUFFERS     = 2
) (
    input  logic                      rgbClk,
    input  logic                      nrst,
    input  logic [23:0]               rgb,
    input  logic                      hsync,
    input  logic                      vsync,
    input  logic                      mode,
    rgb_frame_writer_if.master        ramPort,
    output logic                      frameDone,
    output logic [1:0]                frameBuffer,
    output logic                      frameError
);

    localparam int FRAME_PIXELS = IMAGE_W * IMAGE_H;
    localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_PIXELS);

    if (RAM_DATA_WIDTH != 16) begin : gBadDataWidth
        $error("rgb_frame_writer: RAM_DATA_WIDTH must be 16");
    end
    if ((FRAME_PIXELS % 2) != 0) begin : gOddFrame
        $error("rgb_frame_writer: IMAGE_W*IMAGE_H must be even");
    end
    if (NB_BUFFERS < 1 || NB_BUFFERS > 4) begin : gBadBufCount
        $error("rgb_frame_writer: NB_BUFFERS must be 1..4");
    end
    if ($clog2(NB_BUFFERS * FRAME_PIXELS) > RAM_ADDR_WIDTH) begin : gAddrTooNarrow
        $error("rgb_frame_writer: frame buffers do not fit in RAM_ADDR_WIDTH");
    end

    frameState_t             state;
    frameState_t             stateNext;
    pixMode_t                modeLatched;
    logic [CNT_W-1:0]        pixCount;
    logic [CNT_W-1:0]        wordIdx;
    logic                    overflowSeen;
    logic [1:0]              bufIdx;

    logic                    isMarker;
    logic                    isPixel;
    logic                    pixAccept;
    logic                    pixOverflow;
    logic                    frameClose;
    logic                    frameGood;

    logic                    packIn;
    logic                    pairValid;
    logic [15:0]             pairWord;
    logic                    wrValid;
    logic [15:0]             wrData;
    logic [RAM_ADDR_WIDTH-1:0] bufBase;
    logic [RAM_ADDR_WIDTH-1:0] wrAddr;

    // Both syncs high marks a frame boundary; either one alone is plain blanking.
    assign isMarker = hsync & vsync;
    assign isPixel  = ~(hsync | vsync);

    // State register.
    always_ff @(posedge rgbClk) begin
        if (!nrst) begin
            state <= WAIT_FRAME;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and per-cycle decode of the incoming stream.
    always_comb begin
        stateNext   = state;
        pixAccept   = 1'b0;
        pixOverflow = 1'b0;
        frameClose  = 1'b0;
        frameGood   = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (isMarker) begin
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (isMarker) begin
                    frameClose = 1'b1;
                    // A frame that ran long saturates the count, so the
                    // overflow flag is what tells it apart from a clean one.
                    frameGood  = (pixCount == FRAME_FULL) && !overflowSeen;
                end else if (isPixel) begin
                    if (pixCount == FRAME_FULL) begin
                        pixOverflow = 1'b1;
                    end else begin
                        pixAccept = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = WAIT_FRAME;
            end
        endcase
    end

    // Output format is sampled only at frame boundaries.
    always_ff @(posedge rgbClk) begin
        if (!nrst) begin
            modeLatched <= PIX_RGB565;
        end else if (isMarker) begin
            modeLatched <= pixMode_t'(mode);
        end
    end

    assign packIn = pixAccept && (modeLatched == PIX_RGB332);

    rgb_pixel_packer uPacker (
        .rgbClk    (rgbClk),
        .nrst      (nrst),
        .clear     (isMarker),
        .pixValid  (packIn),
        .rgb       (rgb),
        .pairValid (pairValid),
        .pairWord  (pairWord)
    );

    assign wrValid = (pixAccept && (modeLatched == PIX_RGB565)) || pairValid;
    assign wrData  = (modeLatched == PIX_RGB332) ? pairWord : packRgb565(rgb);
    // Buffer base is in words of one RGB565 frame whatever the mode, so
    // RGB332 frames leave the upper half of their slot untouched.
    assign bufBase = RAM_ADDR_WIDTH'(bufIdx) * RAM_ADDR_WIDTH'(FRAME_PIXELS);
    assign wrAddr  = bufBase + RAM_ADDR_WIDTH'(wordIdx);

    // Pixel and word counters restart at every marker.
    always_ff @(posedge rgbClk) begin
        if (!nrst) begin
            pixCount     <= '0;
            wordIdx      <= '0;
            overflowSeen <= 1'b0;
        end else if (isMarker) begin
            pixCount     <= '0;
            wordIdx      <= '0;
            overflowSeen <= 1'b0;
        end else begin
            if (pixAccept) begin
                pixCount <= pixCount + CNT_W'(1);
            end
            if (wrValid) begin
                wordIdx <= wordIdx + CNT_W'(1);
            end
            if (pixOverflow) begin
                overflowSeen <= 1'b1;
            end
        end
    end

    // Registered RAM write port; address and data hold between writes.
    always_ff @(posedge rgbClk) begin
        if (!nrst) begin
            ramPort.ramAddr     <= '0;
            ramPort.ramData     <= '0;
            ramPort.writeEnable <= 1'b0;
        end else begin
            ramPort.writeEnable <= wrValid;
            if (wrValid) begin
                ramPort.ramAddr <= wrAddr;
                ramPort.ramData <= wrData;
            end
        end
    end

    // Frame completion, buffer rotation and sticky error status.
    always_ff @(posedge rgbClk) begin
        if (!nrst) begin
            frameDone   <= 1'b0;
            frameBuffer <= 2'd0;
            frameError  <= 1'b0;
            bufIdx      <= 2'd0;
        end else begin
            frameDone <= frameGood;
            if (frameGood) begin
                frameBuffer <= bufIdx;
                frameError  <= 1'b0;
                bufIdx      <= (bufIdx == 2'(NB_BUFFERS - 1)) ? 2'd0 : bufIdx + 2'd1;
            end else if (frameClose || pixOverflow) begin
                // Bad frame keeps bufIdx so the next frame overwrites it.
                frameError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Randomized stream bench for rgb_frame_writer with a frame-level reference model.
// Latency: expects each write one cycle after its last pixel, frameDone one cycle after the marker.
// Backpressure: n/a; the bench accepts every write.
module tb_rgb_frame_writer;

    localparam int W    = 80;
    localparam int H    = 48;
    localparam int SIZE = W * H;
    localparam int NB   = 2;

    logic        rgbClk = 1'b0;
    logic        nrst;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        mode;
    logic        frameDone;
    logic [1:0]  frameBuffer;
    logic        frameError;

    rgb_frame_writer_if #(.ADDR_W(32), .DATA_W(16)) ramBus ();

    rgb_frame_writer #(
        .IMAGE_W        (W),
        .IMAGE_H        (H),
        .RAM_ADDR_WIDTH (32),
        .RAM_DATA_WIDTH (16),
        .NB_BUFFERS     (NB)
    ) dut (
        .rgbClk      (rgbClk),
        .nrst        (nrst),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .mode        (mode),
        .ramPort     (ramBus),
        .frameDone   (frameDone),
        .frameBuffer (frameBuffer),
        .frameError  (frameError)
    );

    always #5 rgbClk = ~rgbClk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [23:0] pix;
        int          cyc;
    } pix_t;

    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;
    int   markerCyc = 0;

    wr_t  wrQ[$];
    wr_t  expQ[$];
    int   doneCyc[$];
    logic [1:0] doneBuf[$];
    pix_t pixQ[$];

    // Reference model state, frame granularity.
    bit   active = 1'b0;
    int   bufExp = 0;
    int   bufLastExp = 0;
    bit   errExp = 1'b0;
    bit   modeExp = 1'b0;

    always @(posedge rgbClk) cyc++;

    // Record every write and frame pulse with the cycle it was seen.
    always @(negedge rgbClk) begin
        if (ramBus.writeEnable === 1'b1) begin
            wr_t w;
            w.addr = ramBus.ramAddr;
            w.data = ramBus.ramData;
            w.cyc  = cyc;
            wrQ.push_back(w);
        end
        if (frameDone === 1'b1) begin
            doneCyc.push_back(cyc);
            doneBuf.push_back(frameBuffer);
        end
    end

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    function automatic logic [7:0] to332(input logic [23:0] p);
        return {p[23:21], p[15:13], p[7:6]};
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge rgbClk);
    endtask

    // One active pixel, sometimes preceded by a single-sync blanking cycle.
    task automatic sendPixel(input logic [23:0] p);
        if ($urandom_range(7) == 0) begin
            tick();
            hsync = 1'($urandom_range(1));
            vsync = ~hsync;
            rgb   = $urandom;
            mode  = 1'($urandom_range(1));
        end
        tick();
        hsync = 1'b0;
        vsync = 1'b0;
        rgb   = p;
        mode  = 1'($urandom_range(1));
        if (active) begin
            pix_t e;
            e.pix = p;
            e.cyc = cyc;
            pixQ.push_back(e);
        end
    endtask

    task automatic sendRandom(input int n);
        for (int i = 0; i < n; i++) sendPixel($urandom);
    endtask

    // Marker cycle, then an idle cycle so its results have been observed.
    task automatic markerCycles(input bit m);
        tick();
        hsync = 1'b1;
        vsync = 1'b1;
        rgb   = $urandom;
        mode  = m;
        markerCyc = cyc;
        tick();
        hsync = 1'b1;
        vsync = 1'b0;
        mode  = 1'($urandom_range(1));
        tick();
    endtask

    // Expected words for the pixels of the current frame, from the format rules.
    task automatic compareWrites(input string tag);
        int accepted;
        logic [31:0] base;
        wr_t e;
        accepted = (pixQ.size() > SIZE) ? SIZE : pixQ.size();
        base = 32'(bufExp * SIZE);
        expQ.delete();
        if (!modeExp) begin
            for (int i = 0; i < accepted; i++) begin
                e.addr = base + 32'(i);
                e.data = to565(pixQ[i].pix);
                e.cyc  = pixQ[i].cyc + 1;
                expQ.push_back(e);
            end
        end else begin
            for (int i = 0; i < accepted / 2; i++) begin
                e.addr = base + 32'(i);
                e.data = {to332(pixQ[2*i].pix), to332(pixQ[2*i+1].pix)};
                e.cyc  = pixQ[2*i+1].cyc + 1;
                expQ.push_back(e);
            end
        end
        checkVal({tag, "_nwrites"}, wrQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < wrQ.size()) begin
                checkVal({tag, "_addr"}, wrQ[i].addr, expQ[i].addr);
                checkVal({tag, "_data"}, wrQ[i].data, expQ[i].data);
                checkVal({tag, "_wrcyc"}, wrQ[i].cyc, expQ[i].cyc);
            end
        end
    endtask

    task automatic endFrame(input string tag, input bit m);
        if (active) begin
            compareWrites(tag);
            if (pixQ.size() == SIZE) begin
                checkVal({tag, "_doneCount"}, doneCyc.size(), 1);
                if (doneCyc.size() > 0) begin
                    checkVal({tag, "_doneCyc"}, doneCyc[0], markerCyc + 1);
                    checkVal({tag, "_doneBuf"}, doneBuf[0], bufExp);
                end
                bufLastExp = bufExp;
                bufExp     = (bufExp + 1) % NB;
                errExp     = 1'b0;
            end else begin
                checkVal({tag, "_doneCount"}, doneCyc.size(), 0);
                errExp = 1'b1;
            end
        end else begin
            checkVal({tag, "_idleWrites"}, wrQ.size(), 0);
            checkVal({tag, "_idleDone"}, doneCyc.size(), 0);
        end
        checkVal({tag, "_frameError"}, frameError, errExp);
        checkVal({tag, "_frameBuffer"}, frameBuffer, bufLastExp);
        wrQ.delete();
        doneCyc.delete();
        doneBuf.delete();
        pixQ.delete();
        active  = 1'b1;
        modeExp = m;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_ramAddr"}, ramBus.ramAddr, 0);
        checkVal({tag, "_ramData"}, ramBus.ramData, 0);
        checkVal({tag, "_writeEnable"}, ramBus.writeEnable, 0);
        checkVal({tag, "_frameDone"}, frameDone, 0);
        checkVal({tag, "_frameBuffer"}, frameBuffer, 0);
        checkVal({tag, "_frameError"}, frameError, 0);
    endtask

    // One-cycle reset carried on top of a pixel in the middle of a frame.
    task automatic resetMid();
        tick();
        nrst  = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        rgb   = $urandom;
        mode  = 1'($urandom_range(1));
        tick();
        checkAllZero("midReset");
        nrst = 1'b1;
        compareWrites("preReset");
        checkVal("preReset_doneCount", doneCyc.size(), 0);
        wrQ.delete();
        doneCyc.delete();
        doneBuf.delete();
        pixQ.delete();
        active     = 1'b0;
        bufExp     = 0;
        bufLastExp = 0;
        errExp     = 1'b0;
        modeExp    = 1'b0;
    endtask

    initial begin
        nrst  = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        rgb   = 24'd0;
        mode  = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        nrst = 1'b1;

        // Pixels before the first marker are dropped.
        sendRandom(50);
        markerCycles(1'b0);
        endFrame("pre", 1'b0);

        // Frame A: RGB565 constant colour into buffer 0.
        for (int i = 0; i < SIZE; i++) sendPixel(24'hFF8040);
        markerCycles(1'b1);
        if (wrQ.size() > 0) begin
            checkVal("A_firstData", wrQ[0].data, 16'hFC08);
            checkVal("A_firstAddr", wrQ[0].addr, 0);
            checkVal("A_lastAddr", wrQ[wrQ.size()-1].addr, 3839);
        end
        checkVal("A_frameBuffer", frameBuffer, 0);
        endFrame("A", 1'b1);

        // Frame B: RGB332 pairs into buffer 1.
        for (int i = 0; i < SIZE / 2; i++) begin
            sendPixel(24'hE0E0C0);
            sendPixel(24'h000000);
        end
        markerCycles(1'b1);
        checkVal("B_nwords", wrQ.size(), 1920);
        if (wrQ.size() > 0) begin
            checkVal("B_firstData", wrQ[0].data, 16'hFF00);
            checkVal("B_firstAddr", wrQ[0].addr, 3840);
            checkVal("B_lastAddr", wrQ[wrQ.size()-1].addr, 5759);
        end
        checkVal("B_frameBuffer", frameBuffer, 1);
        endFrame("B", 1'b1);

        // Frame C: random RGB332, rotation wraps back to buffer 0.
        sendRandom(SIZE);
        markerCycles(1'b0);
        if (wrQ.size() > 0) checkVal("C_firstAddr", wrQ[0].addr, 0);
        checkVal("C_frameBuffer", frameBuffer, 0);
        endFrame("C", 1'b0);

        // Frame D: short frame, no completion, error raised.
        sendRandom(3000);
        markerCycles(1'b0);
        checkVal("D_frameError", frameError, 1);
        endFrame("D", 1'b0);

        // Frame E: good frame rewriting the same buffer as D.
        sendRandom(SIZE);
        markerCycles(1'b0);
        if (wrQ.size() > 0) checkVal("E_firstAddr", wrQ[0].addr, 3840);
        endFrame("E", 1'b0);

        // Frame F: long frame, writes capped, error raised on overflow.
        sendRandom(3900);
        checkVal("F_errMid", frameError, 1);
        markerCycles(1'b1);
        checkVal("F_nwrites", wrQ.size(), 3840);
        endFrame("F", 1'b1);

        // Frame G: reset at pixel 1000, then pixels ignored until a marker.
        sendRandom(999);
        resetMid();
        sendRandom(200);
        markerCycles(1'b1);
        endFrame("post", 1'b1);

        // Frame H: clean restart into buffer 0.
        sendRandom(SIZE);
        markerCycles(1'b0);
        if (wrQ.size() > 0) checkVal("H_firstAddr", wrQ[0].addr, 0);
        endFrame("H", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
